// File: rtl/ram_seq_pkg.sv
// ram_seq_pkg
//   Shared types and constants for the ram_word_sequencer slice.
//   size_e  : request size encoding as carried on req_size.
//   state_e : sequencer FSM states.
//   BYTES_PER_BEAT : bytes moved per RAM beat (ports A and B together).
//   Optional build macro used by the slice: RAM_SEQ_MISALIGN_EN.
package ram_seq_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        RESP
    } state_e;

    localparam int unsigned BYTES_PER_BEAT = 2;

endpackage

// File: rtl/ram_word_sequencer_load_ext.sv
// ram_seq_load_ext
//   Purely combinational load-data extension.
//   Ports:
//     size        in  2   request size (byte/half/word; reserved passes through)
//     is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//     raw         in  32  assembled little-endian load bytes
//     ext         out 32  extended result
module ram_seq_load_ext
    import ram_seq_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        unique case (size_e'(size))
            SZ_BYTE: ext = {{24{raw[7]  & ~is_unsigned}}, raw[7:0]};
            SZ_HALF: ext = {{16{raw[15] & ~is_unsigned}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/ram_word_sequencer.sv
// ram_word_sequencer
//   Splits 32-bit byte/half/word load/store requests into beats on a
//   byte-wide dual-port RAM (port A = even byte of the beat, port B = odd),
//   and returns extended load data or an error on a one-cycle strobe.
//   Optional macro RAM_SEQ_MISALIGN_EN: when defined, misaligned half/word
//   accesses are performed with address wrap instead of raising rsp_err.
//   Ports:
//     clk, rst                 clock, async active-high reset
//     req_valid/req_ready      request handshake
//     req_we, req_size, req_unsigned, req_addr, req_wdata   request fields
//     rsp_valid, rsp_rdata, rsp_err                         response
//     ram_addr_a/b, ram_wdata_a/b, ram_we_a/b, ram_rdata_a/b RAM ports
module ram_word_sequencer
    import ram_seq_pkg::*;
#(
    parameter int unsigned ADDR_W           = 10,
    parameter bit          RESP_ZERO_ON_ERR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [7:0]        ram_wdata_a,
    output logic              ram_we_a,
    input  logic [7:0]        ram_rdata_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic [7:0]        ram_wdata_b,
    output logic              ram_we_b,
    input  logic [7:0]        ram_rdata_b
);

    state_e            state, state_nxt;
    logic              we_q;
    size_e             size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       raw_q;
    logic [31:0]       ext;
    logic              req_err;
    logic              two_port;
    logic [ADDR_W-1:0] beat_base;
    logic [15:0]       beat_wdata;

    always_comb begin
        req_err = (size_e'(req_size) == SZ_RSVD);
`ifndef RAM_SEQ_MISALIGN_EN
        if (size_e'(req_size) == SZ_HALF && req_addr[0])
            req_err = 1'b1;
        if (size_e'(req_size) == SZ_WORD && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
`endif
    end

    // Second beat continues BYTES_PER_BEAT above the base; wraps mod 2^ADDR_W.
    assign two_port   = (size_q != SZ_BYTE);
    assign beat_base  = (state == BEAT1) ? addr_q + ADDR_W'(BYTES_PER_BEAT) : addr_q;
    assign beat_wdata = (state == BEAT1) ? wdata_q[31:16] : wdata_q[15:0];

    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        ram_addr_a  = '0;
        ram_wdata_a = '0;
        ram_we_a    = 1'b0;
        ram_addr_b  = '0;
        ram_wdata_b = '0;
        ram_we_b    = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nxt = req_err ? RESP : BEAT0;
            end
            BEAT0, BEAT1: begin
                ram_addr_a  = beat_base;
                ram_wdata_a = beat_wdata[7:0];
                ram_we_a    = we_q;
                if (two_port) begin
                    ram_addr_b  = beat_base + ADDR_W'(1);
                    ram_wdata_b = beat_wdata[15:8];
                    ram_we_b    = we_q;
                end
                state_nxt = (state == BEAT0 && size_q == SZ_WORD) ? BEAT1 : RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            raw_q   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                size_q  <= size_e'(req_size);
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= req_err;
                raw_q   <= '0;
            end
            if (state == BEAT0 && !we_q) begin
                raw_q[7:0] <= ram_rdata_a;
                if (two_port)
                    raw_q[15:8] <= ram_rdata_b;
            end
            if (state == BEAT1 && !we_q) begin
                raw_q[23:16] <= ram_rdata_a;
                raw_q[31:24] <= ram_rdata_b;
            end
        end
    end

    ram_seq_load_ext u_load_ext (
        .size        (size_q),
        .is_unsigned (uns_q),
        .raw         (raw_q),
        .ext         (ext)
    );

    assign rsp_err   = (state == RESP) && err_q;
    assign rsp_rdata = (state == RESP && !we_q && !(err_q && RESP_ZERO_ON_ERR)) ? ext : '0;

endmodule

// File: tb/tb_ram_word_sequencer.sv
// tb_ram_word_sequencer
//   Self-checking bench: a behavioural dual-port RAM plus a reference memory
//   and a response scoreboard. Honours RAM_SEQ_MISALIGN_EN for expectations.
module tb_ram_word_sequencer;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid, rsp_err;
    logic [31:0]   rsp_rdata;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [7:0]    ram_wdata_a, ram_wdata_b, ram_rdata_a, ram_rdata_b;
    logic          ram_we_a, ram_we_b;

    logic [7:0]    mem     [0:1023];
    logic [7:0]    ref_mem [0:1023];
    logic          tb_fill;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned lat;
        int unsigned acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc    = 0;
    int unsigned we_cnt = 0;
    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;

    ram_word_sequencer #(.ADDR_W(AW), .RESP_ZERO_ON_ERR(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_addr_a(ram_addr_a), .ram_wdata_a(ram_wdata_a), .ram_we_a(ram_we_a),
        .ram_rdata_a(ram_rdata_a),
        .ram_addr_b(ram_addr_b), .ram_wdata_b(ram_wdata_b), .ram_we_b(ram_we_b),
        .ram_rdata_b(ram_rdata_b)
    );

    // Behavioural RAM: async read, posedge write, filled once at start.
    assign ram_rdata_a = mem[ram_addr_a];
    assign ram_rdata_b = mem[ram_addr_b];
    always @(posedge clk) begin
        if (tb_fill) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'(i * 7 + 3);
        end else begin
            if (ram_we_a) mem[ram_addr_a] <= ram_wdata_a;
            if (ram_we_b) mem[ram_addr_b] <= ram_wdata_b;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we_a || ram_we_b) we_cnt <= we_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic model_push(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [AW-1:0] a, input logic [31:0] wd,
                              input int unsigned acc);
        exp_t          e;
        int unsigned   n;
        logic [31:0]   raw;
        logic [AW-1:0] idx;
        n     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e.err = (sz == 2'd3);
`ifndef RAM_SEQ_MISALIGN_EN
        if (sz == 2'd1 && a[0]) e.err = 1'b1;
        if (sz == 2'd2 && a[1:0] != 2'b00) e.err = 1'b1;
`endif
        raw = '0;
        if (!e.err) begin
            for (int unsigned i = 0; i < n; i++) begin
                idx = a + AW'(i);
                if (we) ref_mem[idx] = wd[8*i +: 8];
                else    raw[8*i +: 8] = ref_mem[idx];
            end
        end
        e.rdata = '0;
        if (!e.err && !we) begin
            if (sz == 2'd0)      e.rdata = (!uns && raw[7])  ? (raw | 32'hFFFF_FF00) : raw;
            else if (sz == 2'd1) e.rdata = (!uns && raw[15]) ? (raw | 32'hFFFF_0000) : raw;
            else                 e.rdata = raw;
        end
        e.lat = e.err ? 1 : ((sz == 2'd2) ? 3 : 2);
        e.acc = acc;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [AW-1:0] a, input logic [31:0] wd, input bit expect_rsp);
        int unsigned n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check_eq("ready_timeout", 32'(req_ready), 32'd1);
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        if (expect_rsp) model_push(we, sz, uns, a, wd, cyc);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("rsp_rdata",   rsp_rdata, mon_e.rdata);
                check_eq("rsp_err",     32'(rsp_err), 32'(mon_e.err));
                check_eq("rsp_latency", cyc - mon_e.acc, mon_e.lat);
                check_eq("ready_in_resp", 32'(req_ready), 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned we_before;
        int unsigned mism;
        int unsigned hold_acc;
        rst = 1'b1; tb_fill = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 7 + 3);
        repeat (2) @(posedge clk);
        tb_fill = 1'b0;
        @(negedge clk);
        check_eq("rst_ready",  32'(req_ready), 32'd1);
        check_eq("rst_rsp",    32'({rsp_valid, rsp_err}), 32'd0);
        check_eq("rst_rdata",  rsp_rdata, 32'd0);
        check_eq("rst_we",     32'({ram_we_a, ram_we_b}), 32'd0);
        check_eq("rst_addr",   32'({ram_addr_a, ram_addr_b}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        send(1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, 1'b1);
        drain();
        check_eq("st_w_10", 32'(mem[10'h010]), 32'hEF);
        check_eq("st_w_11", 32'(mem[10'h011]), 32'hBE);
        check_eq("st_w_12", 32'(mem[10'h012]), 32'hAD);
        check_eq("st_w_13", 32'(mem[10'h013]), 32'hDE);

        send(1'b0, 2'd0, 1'b0, 10'h013, 32'd0, 1'b1); drain();
        send(1'b0, 2'd0, 1'b1, 10'h013, 32'd0, 1'b1); drain();
        send(1'b0, 2'd1, 1'b0, 10'h012, 32'd0, 1'b1); drain();
        send(1'b0, 2'd1, 1'b1, 10'h012, 32'd0, 1'b1); drain();
        send(1'b0, 2'd2, 1'b0, 10'h010, 32'd0, 1'b1); drain();

        we_before = we_cnt;
        send(1'b0, 2'd1, 1'b0, 10'h011, 32'd0, 1'b1); drain();
`ifndef RAM_SEQ_MISALIGN_EN
        check_eq("err_no_we", we_cnt - we_before, 32'd0);
`endif
        send(1'b0, 2'd3, 1'b0, 10'h020, 32'd0, 1'b1); drain();

        // Word store at the top of memory: wraps when enabled, error otherwise.
        send(1'b1, 2'd2, 1'b0, 10'h3FF, 32'hCAFEF00D, 1'b1);
        drain();
        check_eq("wrap_3ff", 32'(mem[10'h3FF]), 32'(ref_mem[10'h3FF]));
        check_eq("wrap_000", 32'(mem[10'h000]), 32'(ref_mem[10'h000]));
        check_eq("wrap_001", 32'(mem[10'h001]), 32'(ref_mem[10'h001]));
        check_eq("wrap_002", 32'(mem[10'h002]), 32'(ref_mem[10'h002]));

        // req_valid held high through RESP: next accept only in the IDLE cycle.
        while (!req_ready) @(negedge clk);
        req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b1;
        req_addr = 10'h013; req_wdata = '0; req_valid = 1'b1;
        hold_acc = cyc;
        model_push(1'b0, 2'd0, 1'b1, 10'h013, 32'd0, hold_acc);
        model_push(1'b0, 2'd0, 1'b1, 10'h013, 32'd0, hold_acc + 3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        drain();

        // Reset during BEAT1 of a word store: only the first beat lands.
        send(1'b1, 2'd2, 1'b0, 10'h040, 32'h11223344, 1'b0);
        ref_mem[10'h040] = 8'h44;
        ref_mem[10'h041] = 8'h33;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_ready", 32'(req_ready), 32'd1);
        check_eq("midrst_we",    32'({ram_we_a, ram_we_b}), 32'd0);
        check_eq("midrst_rsp",   32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("midrst_40", 32'(mem[10'h040]), 32'h44);
        check_eq("midrst_41", 32'(mem[10'h041]), 32'h33);
        check_eq("midrst_42", 32'(mem[10'h042]), 32'(ref_mem[10'h042]));
        check_eq("midrst_43", 32'(mem[10'h043]), 32'(ref_mem[10'h043]));

        for (int k = 0; k < 30; k++) begin
            send(1'($urandom), 2'($urandom), 1'($urandom), AW'($urandom), $urandom, 1'b1);
            drain();
        end

        mism = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mism++;
        check_eq("mem_final", mism, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
